router_in_ctrl: RTL and testbench
=================================

ROUTER_IN_CTRL -- requirements
Module: router_in_ctrl

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: pkt_valid  in  1  upstream byte valid.
REQ-004 SHALL have: data_in  in  8  upstream byte; header [1:0]=addr, [7:2]=payload length.
REQ-005 SHALL have: fifo_full  in  3 / fifo_empty  in  3 / read_enb  in  3  per-FIFO status and read strobes.
REQ-006 SHALL have: busy  out  1  upstream stall; byte accepted only when pkt_valid=1 and busy=0.
REQ-007 SHALL have: write_enb  out  3 / lfd_state  out  3  one-hot FIFO write and header-load strobes.
REQ-008 SHALL have: dout  out  8  byte to FIFOs; soft_reset_n  out  3  active-low FIFO flush; err  out  1  parity error.

Function
REQ-009 SHALL implement states IDLE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, LOAD_PARITY, CHECK_PARITY, DROP.
REQ-010 IDLE, pkt_valid=1, addr<3: capture hdr_reg=data_in, addr_reg, cnt=data_in[7:2], par=data_in; -> LOAD_FIRST if fifo_empty[addr]=1, else WAIT_EMPTY.
REQ-011 IDLE, pkt_valid=1, addr=3: -> DROP; no FIFO write.
REQ-012 WAIT_EMPTY: busy=1; -> LOAD_FIRST on fifo_empty[addr_reg]=1.
REQ-013 LOAD_FIRST: busy=1, dout=hdr_reg, write_enb[addr_reg]=1, lfd_state[addr_reg]=1 for exactly one cycle; -> LOAD_DATA (cnt>0) or LOAD_PARITY (cnt=0).
REQ-014 LOAD_DATA: busy=fifo_full[addr_reg]; byte written when pkt_valid=1 and full=0 (write_enb[addr_reg]=1, dout=data_in, par^=data_in, cnt-=1); -> LOAD_PARITY when cnt decrements 1->0.
REQ-015 LOAD_PARITY: same write rule; accepted byte stored as rx_par and written to FIFO; -> CHECK_PARITY.
REQ-016 CHECK_PARITY: busy=1, one cycle; err<=(rx_par!=par); -> IDLE.
REQ-017 err SHALL hold until next CHECK_PARITY or reset.
REQ-018 DROP: busy=0, bytes discarded; -> IDLE when pkt_valid=0.
REQ-019 pkt_valid=0 in LOAD_DATA/LOAD_PARITY: no write, no state change, no timeout.
REQ-020 Outside write cycles: write_enb=0, lfd_state=0, dout=8'h00; at most one write_enb bit high per cycle.
REQ-021 busy, write_enb, lfd_state, dout SHALL be combinational from state, registers, pkt_valid, data_in, fifo_full.
REQ-022 Per FIFO i: 5-bit timer increments when fifo_empty[i]=0 and read_enb[i]=0, clears otherwise.
REQ-023 Timer reaching 29 (30th idle cycle): soft_reset_n[i]=0 registered for one cycle, timer cleared.
REQ-024 soft_reset_n[i] pulse while state!=IDLE and addr_reg==i: FSM -> IDLE next cycle, packet abandoned, err unchanged.
REQ-025 Payload length 0 legal (header+parity only); max 63; cnt 6 bits, no wrap.

Reset
REQ-026 reset=1 SHALL asynchronously force state=IDLE, cnt=0, par=0, hdr_reg=0, timers=0, err=0, soft_reset_n=3'b111.
REQ-027 During and after reset until first IDLE header: busy=0, write_enb=0, lfd_state=0, dout=8'h00.
REQ-028 Reset mid-packet SHALL abandon packet with no further FIFO writes.

Verification
REQ-029 Header 8'h0D (addr1,len3), payload 11,22,33, parity 8'h0D^11^22^33=8'h0D, FIFO1 empty -> lfd_state=3'b010 one cycle, 5 writes to FIFO1, err=0.
REQ-030 Same packet, parity byte 8'hFF -> 5 writes, err=1 after CHECK_PARITY, cleared by next good packet.
REQ-031 fifo_full[0]=1 for 4 cycles mid-payload -> busy=1, write_enb=0 those cycles, no byte lost, resumes on full=0.
REQ-032 Header addr=3, 4 bytes, pkt_valid low -> no write_enb, busy=0, back to IDLE.
REQ-033 FIFO2 non-empty, read_enb[2]=0 for 30 cycles -> soft_reset_n[2]=0 on 30th cycle for one cycle; header to addr2 waits in WAIT_EMPTY busy=1.
REQ-034 reset asserted mid-LOAD_DATA -> outputs to reset values same cycle, IDLE after release.

Source files
------------

// File: rtl/router_in_ctrl.sv
// Router input controller: parses header/payload/parity bytes from the upstream port,
// steers them into one of three output FIFOs, checks parity and flushes stale FIFOs.
module router_in_ctrl (
   input  logic       clock,
   input  logic       reset,
   input  logic       pkt_valid,
   input  logic [7:0] data_in,
   input  logic [2:0] fifo_full,
   input  logic [2:0] fifo_empty,
   input  logic [2:0] read_enb,
   output logic       busy,
   output logic [2:0] write_enb,
   output logic [2:0] lfd_state,
   output logic [7:0] dout,
   output logic [2:0] soft_reset_n,
   output logic       err
);

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned CNT_W   = 6;
   localparam int unsigned TIMER_W = 5;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(29);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_EMPTY,
      LOAD_FIRST,
      LOAD_DATA,
      LOAD_PARITY,
      CHECK_PARITY,
      DROP
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [DATA_W-1:0]   hdr_reg;
   logic [DATA_W-1:0]   par;
   logic [DATA_W-1:0]   rx_par;
   logic [CNT_W-1:0]    cnt;
   logic [1:0]          addr_reg;
   logic [TIMER_W-1:0]  timer [3];

   logic [3:0] full4;
   logic [3:0] empty4;
   logic [3:0] srst4;
   logic [2:0] sel;
   logic       accept;
   logic       abort;

   // Address 3 has no FIFO: padding makes it read as never-empty/never-full/never-flushed.
   assign full4  = {1'b0, fifo_full};
   assign empty4 = {1'b0, fifo_empty};
   assign srst4  = {1'b1, soft_reset_n};
   assign sel    = 3'(4'b0001 << addr_reg);
   assign accept = pkt_valid && !full4[addr_reg];
   assign abort  = (state != IDLE) && !srst4[addr_reg];

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; a flush of the active FIFO abandons the packet
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (pkt_valid) begin
               if (data_in[1:0] == 2'd3)           state_next = DROP;
               else if (empty4[data_in[1:0]])      state_next = LOAD_FIRST;
               else                                state_next = WAIT_EMPTY;
            end
         end
         WAIT_EMPTY:   if (empty4[addr_reg]) state_next = LOAD_FIRST;
         LOAD_FIRST:   state_next = (cnt != '0) ? LOAD_DATA : LOAD_PARITY;
         LOAD_DATA:    if (accept && cnt == CNT_W'(1)) state_next = LOAD_PARITY;
         LOAD_PARITY:  if (accept) state_next = CHECK_PARITY;
         CHECK_PARITY: state_next = IDLE;
         DROP:         if (!pkt_valid) state_next = IDLE;
         default:      state_next = IDLE;
      endcase
      if (abort) state_next = IDLE;
   end

   // Output decode (combinational from state and live inputs)
   always_comb begin
      busy      = 1'b0;
      write_enb = '0;
      lfd_state = '0;
      dout      = '0;
      unique case (state)
         IDLE:         busy = 1'b0;
         WAIT_EMPTY:   busy = 1'b1;
         LOAD_FIRST: begin
            busy      = 1'b1;
            dout      = hdr_reg;
            write_enb = sel;
            lfd_state = sel;
         end
         LOAD_DATA, LOAD_PARITY: begin
            busy = full4[addr_reg];
            if (accept) begin
               write_enb = sel;
               dout      = data_in;
            end
         end
         CHECK_PARITY: busy = 1'b1;
         DROP:         busy = 1'b0;
         default:      busy = 1'b0;
      endcase
   end

   // Packet datapath: header capture, byte count, running parity, error flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hdr_reg  <= '0;
         addr_reg <= '0;
         cnt      <= '0;
         par      <= '0;
         rx_par   <= '0;
         err      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pkt_valid) begin
                  hdr_reg  <= data_in;
                  addr_reg <= data_in[1:0];
                  cnt      <= data_in[7:2];
                  par      <= data_in;
               end
            end
            LOAD_DATA: begin
               if (accept && !abort) begin
                  par <= par ^ data_in;
                  cnt <= cnt - CNT_W'(1);
               end
            end
            LOAD_PARITY:  if (accept) rx_par <= data_in;
            CHECK_PARITY: if (!abort) err <= (rx_par != par);
            default: ;
         endcase
      end
   end

   // Per-FIFO stall timers: 30 consecutive unread non-empty cycles trigger a flush pulse
   for (genvar g = 0; g < 3; g++) begin : g_timer
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            timer[g]        <= '0;
            soft_reset_n[g] <= 1'b1;
         end else if (!fifo_empty[g] && !read_enb[g]) begin
            if (timer[g] == TIMER_LAST) begin
               timer[g]        <= '0;
               soft_reset_n[g] <= 1'b0;
            end else begin
               timer[g]        <= timer[g] + TIMER_W'(1);
               soft_reset_n[g] <= 1'b1;
            end
         end else begin
            timer[g]        <= '0;
            soft_reset_n[g] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_router_in_ctrl.sv
// Scoreboard bench for router_in_ctrl: expected FIFO writes are queued by the stimulus
// and popped by a negedge monitor; status outputs are checked directly.
module tb_router_in_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] read_enb;
   logic       busy;
   logic [2:0] write_enb;
   logic [2:0] lfd_state;
   logic [7:0] dout;
   logic [2:0] soft_reset_n;
   logic       err;

   typedef struct packed {
      logic [2:0] we;
      logic [2:0] lfd;
      logic [7:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  tests  = 0;
   int  failed = 0;

   router_in_ctrl dut (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
      .busy(busy), .write_enb(write_enb), .lfd_state(lfd_state), .dout(dout),
      .soft_reset_n(soft_reset_n), .err(err)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] addr, input logic first, input logic [7:0] d);
      wr_t e;
      e.we  = 3'(4'b0001 << addr);
      e.lfd = first ? e.we : 3'b000;
      e.d   = d;
      exp_q.push_back(e);
   endtask

   // Present a byte and hold it until the DUT accepts it (busy low at the preceding negedge)
   task automatic send(input logic [7:0] b);
      int n = 0;
      pkt_valid = 1'b1;
      data_in   = b;
      forever begin
         @(negedge clock);
         if (!busy) break;
         n++;
         if (n > 200) begin
            check("send_timeout", 32'(n), 32'd0);
            break;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic pkt5(input logic [7:0] h, p1, p2, p3, pr);
      push(h[1:0], 1'b1, h);
      push(h[1:0], 1'b0, p1);
      push(h[1:0], 1'b0, p2);
      push(h[1:0], 1'b0, p3);
      push(h[1:0], 1'b0, pr);
      send(h); send(p1); send(p2); send(p3); send(pr);
      pkt_valid = 1'b0;
      @(posedge clock);
      #1;
   endtask

   // Monitor: every write strobe must match the head of the expected queue
   always @(negedge clock) begin
      if (write_enb != 3'b000 || lfd_state != 3'b000) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {21'd0, write_enb, lfd_state, dout}, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_data", {21'd0, write_enb, lfd_state, dout}, {21'd0, e});
         end
      end else begin
         check("idle_dout", {24'd0, dout}, 32'd0);
      end
   end

   initial begin
      reset      = 1'b1;
      pkt_valid  = 1'b0;
      data_in    = 8'h00;
      fifo_full  = 3'b000;
      fifo_empty = 3'b111;
      read_enb   = 3'b000;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_we", 32'(write_enb), 32'd0);
      check("rst_lfd", 32'(lfd_state), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_srst", 32'(soft_reset_n), 32'd7);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Good packet to FIFO1
      pkt5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
      check("good_err", 32'(err), 32'd0);

      // Bad parity then a good packet clears err
      pkt5(8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF);
      check("bad_err", 32'(err), 32'd1);
      pkt5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
      check("err_cleared", 32'(err), 32'd0);

      // FIFO0 full for 4 cycles mid-payload
      push(2'd0, 1'b1, 8'h0C);
      push(2'd0, 1'b0, 8'hAA);
      push(2'd0, 1'b0, 8'hBB);
      push(2'd0, 1'b0, 8'hCC);
      push(2'd0, 1'b0, 8'hD1);
      send(8'h0C);
      send(8'hAA);
      fifo_full = 3'b001;
      data_in   = 8'hBB;
      repeat (4) begin
         @(negedge clock);
         check("full_busy", 32'(busy), 32'd1);
         check("full_we", 32'(write_enb), 32'd0);
      end
      @(posedge clock);
      #1;
      fifo_full = 3'b000;
      send(8'hBB); send(8'hCC); send(8'hD1);
      pkt_valid = 1'b0;
      @(posedge clock);
      #1;
      check("full_err", 32'(err), 32'd0);

      // Address 3 is dropped
      send(8'h0F);
      for (int i = 0; i < 3; i++) begin
         pkt_valid = 1'b1;
         data_in   = 8'h40 + 8'(i);
         @(negedge clock);
         check("drop_busy", 32'(busy), 32'd0);
         @(posedge clock);
         #1;
      end
      pkt_valid = 1'b0;
      @(posedge clock);
      #1;

      // FIFO2 stall timer: flush pulse after the 30th idle cycle only
      fifo_empty = 3'b011;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clock);
         #1;
         check($sformatf("srst2_c%0d", k), 32'(soft_reset_n), (k == 30) ? 32'd3 : 32'd7);
      end

      // Header to non-empty FIFO2 waits, then proceeds once empty
      push(2'd2, 1'b1, 8'h06);
      push(2'd2, 1'b0, 8'h55);
      push(2'd2, 1'b0, 8'h53);
      pkt_valid = 1'b1;
      data_in   = 8'h06;
      @(posedge clock);
      #1;
      pkt_valid = 1'b0;
      repeat (5) begin
         @(negedge clock);
         check("wait_busy", 32'(busy), 32'd1);
      end
      @(posedge clock);
      #1;
      fifo_empty = 3'b111;
      send(8'h55); send(8'h53);
      pkt_valid = 1'b0;
      @(posedge clock);
      #1;
      check("wait_err", 32'(err), 32'd0);

      // Set err, then reset mid-payload
      pkt5(8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF);
      check("bad2_err", 32'(err), 32'd1);
      push(2'd1, 1'b1, 8'h0D);
      push(2'd1, 1'b0, 8'h11);
      send(8'h0D); send(8'h11);
      pkt_valid = 1'b0;
      #1;
      reset     = 1'b1;
      pkt_valid = 1'b1;
      data_in   = 8'h22;
      #1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_we", 32'(write_enb), 32'd0);
      check("mid_lfd", 32'(lfd_state), 32'd0);
      check("mid_dout", 32'(dout), 32'd0);
      check("mid_err", 32'(err), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset     = 1'b0;
      pkt_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);

      // Back in IDLE: a fresh packet goes through
      pkt5(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
      check("post_rst_err", 32'(err), 32'd0);
      repeat (2) @(posedge clock);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
